// File: rtl/symbol_decode.sv
// symbol_decode
//
// Turns a stream of measured line symbols (level + length in clk cycles) into
// bytes. A long low symbol (SYNC) opens a frame. Inside a frame, each high
// pulse carries one bit: a SHORT pulse is 0 and a LONG pulse is 1, MSB first.
// Low SHORT symbols are gaps between bits. After eight bits the byte is held
// on a valid/ready handshake while the symbol input is stalled.
//
// State table
//   state | meaning
//   IDLE  | waiting for SYNC; all other symbols are discarded silently
//   DATA  | inside a frame, collecting bits
//   HOLD  | full byte presented downstream, symbol input stalled
//
// Optional feature: define SYMBOL_DECODE_STAT_EN to add an 8-bit saturating
// error counter output (err_cnt_o).
//
// Ports
//   clk_i       single clock, rising edge
//   rst_i       synchronous active-high reset
//   sym_vld_i   measured symbol valid
//   sym_rdy_o   symbol accepted when sym_vld_i && sym_rdy_o (state only)
//   sym_lvl_i   line level of the symbol (1 = high pulse)
//   sym_len_i   symbol length in clk cycles
//   byte_vld_o  decoded byte valid
//   byte_rdy_i  downstream ready
//   byte_dat_o  decoded byte, first received bit in bit 7
//   err_pls_o   one-cycle pulse on framing/width error
//   err_cnt_o   saturating error count (SYMBOL_DECODE_STAT_EN only)

module symbol_decode #(
    parameter int LEN_W     = 16,
    parameter int SHORT_MIN = 8,
    parameter int SHORT_MAX = 12,
    parameter int LONG_MIN  = 16,
    parameter int LONG_MAX  = 24,
    parameter int SYNC_MIN  = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sym_vld_i,
    output logic             sym_rdy_o,
    input  logic             sym_lvl_i,
    input  logic [LEN_W-1:0] sym_len_i,
    output logic             byte_vld_o,
    input  logic             byte_rdy_i,
    output logic [7:0]       byte_dat_o,
    output logic             err_pls_o
`ifdef SYMBOL_DECODE_STAT_EN
    ,
    output logic [7:0]       err_cnt_o
`endif
);

    localparam logic [LEN_W-1:0] SHORT_MIN_L = LEN_W'(SHORT_MIN);
    localparam logic [LEN_W-1:0] SHORT_MAX_L = LEN_W'(SHORT_MAX);
    localparam logic [LEN_W-1:0] LONG_MIN_L  = LEN_W'(LONG_MIN);
    localparam logic [LEN_W-1:0] LONG_MAX_L  = LEN_W'(LONG_MAX);
    localparam logic [LEN_W-1:0] SYNC_MIN_L  = LEN_W'(SYNC_MIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;      // only 7 bits need storing; bit 8 goes straight to byte_dat
    logic [7:0] byte_dat_q, byte_dat_d;
    logic       byte_vld_q, byte_vld_d;
    logic       err_pls_q, err_pls_d;

    logic is_short, is_long, is_sync, sym_acc;

    always_comb begin
        is_short = (sym_len_i >= SHORT_MIN_L) && (sym_len_i <= SHORT_MAX_L);
        is_long  = (sym_len_i >= LONG_MIN_L)  && (sym_len_i <= LONG_MAX_L);
        is_sync  = !sym_lvl_i && (sym_len_i >= SYNC_MIN_L);
    end

    assign sym_rdy_o = (state_q != ST_HOLD);
    assign sym_acc   = sym_vld_i && sym_rdy_o;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_dat_d = byte_dat_q;
        byte_vld_d = byte_vld_q;
        err_pls_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sym_acc && is_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                    shift_d   = 7'd0;
                end
            end

            ST_DATA: begin
                if (sym_acc) begin
                    if (sym_lvl_i && (is_short || is_long)) begin
                        if (bit_cnt_q == 3'd7) begin
                            byte_dat_d = {shift_q, is_long};
                            byte_vld_d = 1'b1;
                            bit_cnt_d  = 3'd0;
                            shift_d    = 7'd0;
                            state_d    = ST_HOLD;
                        end else begin
                            shift_d   = {shift_q[5:0], is_long};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (!sym_lvl_i && is_short) begin
                        // inter-bit gap, nothing to do
                    end else if (is_sync) begin
                        // resync mid-frame: drop partial bits silently
                        bit_cnt_d = 3'd0;
                        shift_d   = 7'd0;
                    end else begin
                        // BAD width, over-long high pulse, or LONG low gap
                        err_pls_d = 1'b1;
                        bit_cnt_d = 3'd0;
                        shift_d   = 7'd0;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                if (byte_rdy_i) begin
                    byte_vld_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            byte_dat_q <= 8'd0;
            byte_vld_q <= 1'b0;
            err_pls_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_dat_q <= byte_dat_d;
            byte_vld_q <= byte_vld_d;
            err_pls_q  <= err_pls_d;
        end
    end

    assign byte_vld_o = byte_vld_q;
    assign byte_dat_o = byte_dat_q;
    assign err_pls_o  = err_pls_q;

`ifdef SYMBOL_DECODE_STAT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= 8'd0;
        end else if (err_pls_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_symbol_decode.sv
// tb_symbol_decode
//
// Directed bench for symbol_decode. Inputs change 1 ns after the rising edge;
// a negedge monitor counts byte handshakes, byte_vld cycles and error pulses.
// Expected values are hand-computed from the symbol sequences sent.

module tb_symbol_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sym_vld_i;
    logic        sym_rdy_o;
    logic        sym_lvl_i;
    logic [15:0] sym_len_i;
    logic        byte_vld_o;
    logic        byte_rdy_i;
    logic [7:0]  byte_dat_o;
    logic        err_pls_o;
`ifdef SYMBOL_DECODE_STAT_EN
    logic [7:0]  err_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    int       bytes_seen = 0;
    int       vld_cycles = 0;
    int       err_seen   = 0;
    int       err_in_hold = 0;
    logic [7:0] last_byte = 8'h00;

    always #5 clk_i = ~clk_i;

    symbol_decode dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sym_vld_i  (sym_vld_i),
        .sym_rdy_o  (sym_rdy_o),
        .sym_lvl_i  (sym_lvl_i),
        .sym_len_i  (sym_len_i),
        .byte_vld_o (byte_vld_o),
        .byte_rdy_i (byte_rdy_i),
        .byte_dat_o (byte_dat_o),
        .err_pls_o  (err_pls_o)
`ifdef SYMBOL_DECODE_STAT_EN
        ,
        .err_cnt_o  (err_cnt_o)
`endif
    );

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (byte_vld_o && byte_rdy_i) begin
                bytes_seen = bytes_seen + 1;
                last_byte  = byte_dat_o;
            end
            if (byte_vld_o) vld_cycles = vld_cycles + 1;
            if (err_pls_o)  err_seen = err_seen + 1;
            if (err_pls_o && !sym_rdy_o) err_in_hold = err_in_hold + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Present one symbol and hold it until the DUT accepts it (bounded).
    task automatic send(input logic lvl, input int len);
        int n;
        sym_vld_i = 1'b1;
        sym_lvl_i = lvl;
        sym_len_i = 16'(len);
        n = 0;
        while (!sym_rdy_o && n < 50) begin
            tick(1);
            n++;
        end
        if (!sym_rdy_o) chk("sym_rdy_wait", {31'd0, sym_rdy_o}, 32'd1);
        tick(1);
        sym_vld_i = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        send(1'b0, 10);
        send(1'b1, b ? 20 : 10);
    endtask

    task automatic send_frame(input logic [7:0] v);
        send(1'b0, 40);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
    endtask

    int b0, v0, e0;

    initial begin
        rst_i      = 1'b1;
        sym_vld_i  = 1'b0;
        sym_lvl_i  = 1'b0;
        sym_len_i  = 16'd0;
        byte_rdy_i = 1'b1;
        tick(3);
        rst_i = 1'b0;

        // reset state
        chk("rst_sym_rdy",  {31'd0, sym_rdy_o},  32'd1);
        chk("rst_byte_vld", {31'd0, byte_vld_o}, 32'd0);
        chk("rst_err_pls",  {31'd0, err_pls_o},  32'd0);
        chk("rst_byte_dat", {24'd0, byte_dat_o}, 32'd0);

        // IDLE discards non-sync symbols silently
        b0 = bytes_seen; e0 = err_seen;
        send(1'b1, 10); send(1'b1, 20); send(1'b0, 20); send(1'b1, 45); send(1'b0, 3);
        tick(2);
        chk("idle_no_err",  err_seen - e0,   0);
        chk("idle_no_byte", bytes_seen - b0, 0);

        // 0x55 with alternating short/long highs, byte_rdy=1
        b0 = bytes_seen; v0 = vld_cycles; e0 = err_seen;
        send(1'b0, 40);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, (i % 2 == 1) ? 20 : 10);
            send(1'b0, 10);
        end
        tick(3);
        chk("b55_count",  bytes_seen - b0, 1);
        chk("b55_data",   {24'd0, last_byte}, 32'h55);
        chk("b55_vld_1cy", vld_cycles - v0, 1);
        chk("b55_no_err", err_seen - e0, 0);

        // 0xFF held with byte_rdy=0 for 5 cycles
        byte_rdy_i = 1'b0;
        b0 = bytes_seen;
        send(1'b0, 40);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) send(1'b0, 10);
            send(1'b1, 16);
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_sym_rdy",  {31'd0, sym_rdy_o},  32'd0);
            chk("hold_byte_vld", {31'd0, byte_vld_o}, 32'd1);
            chk("hold_byte_dat", {24'd0, byte_dat_o}, 32'hFF);
            tick(1);
        end
        chk("hold_no_hs", bytes_seen - b0, 0);
        byte_rdy_i = 1'b1;
        tick(1);
        chk("hs_count",    bytes_seen - b0, 1);
        chk("hs_data",     {24'd0, last_byte}, 32'hFF);
        chk("hs_vld_drop", {31'd0, byte_vld_o}, 32'd0);
        chk("hs_sym_rdy",  {31'd0, sym_rdy_o},  32'd1);

        // framing kept after handshake: next 8 bits form a byte without sync
        b0 = bytes_seen;
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        tick(2);
        chk("kept_frame_cnt",  bytes_seen - b0, 1);
        chk("kept_frame_data", {24'd0, last_byte}, 32'h55);

        // 3 bits then high len 14 (gap between short and long) -> error
        do_reset();
        b0 = bytes_seen; e0 = err_seen;
        send(1'b0, 40);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send(1'b1, 14);
        chk("gap_err_pls",  {31'd0, err_pls_o}, 32'd1);
        tick(1);
        chk("gap_err_once", {31'd0, err_pls_o}, 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        tick(2);
        chk("gap_err_count", err_seen - e0,   1);
        chk("gap_no_byte",   bytes_seen - b0, 0);

        // low LONG inside a frame -> error
        e0 = err_seen;
        send(1'b0, 40);
        send(1'b0, 20);
        tick(2);
        chk("lowlong_err", err_seen - e0, 1);

        // high SYNC-length pulse inside a frame -> error
        e0 = err_seen;
        send(1'b0, 40);
        send_bit(1'b1);
        send(1'b1, 45);
        tick(2);
        chk("highsync_err", err_seen - e0, 1);

        // boundaries: SHORT_MAX=12 -> 0, LONG_MIN=16 -> 1, LONG_MAX=24 -> 1, SHORT_MIN=8 -> 0
        b0 = bytes_seen; e0 = err_seen;
        send(1'b0, 40);
        send(1'b1, 12); send(1'b0, 8);
        send(1'b1, 16); send(1'b0, 12);
        send(1'b1, 24); send(1'b0, 10);
        send(1'b1, 8);  send(1'b0, 10);
        send(1'b1, 24); send(1'b0, 10);
        send(1'b1, 12); send(1'b0, 10);
        send(1'b1, 16); send(1'b0, 10);
        send(1'b1, 8);
        tick(2);
        chk("bound_byte", {24'd0, last_byte}, 32'h6A);
        chk("bound_cnt",  bytes_seen - b0, 1);
        chk("bound_err",  err_seen - e0, 0);

        // 5 bits, resync with low 50, then 8 shorts -> only 0x00
        b0 = bytes_seen; e0 = err_seen;
        send(1'b0, 40);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send(1'b0, 50);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        tick(2);
        chk("resync_cnt",  bytes_seen - b0, 1);
        chk("resync_data", {24'd0, last_byte}, 32'h00);
        chk("resync_err",  err_seen - e0, 0);

        // reset while HOLD drops pending byte
        byte_rdy_i = 1'b0;
        b0 = bytes_seen;
        send_frame(8'h3C);
        chk("rsthold_vld_before", {31'd0, byte_vld_o}, 32'd1);
        chk("rsthold_dat_before", {24'd0, byte_dat_o}, 32'h3C);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk("rsthold_vld",  {31'd0, byte_vld_o}, 32'd0);
        chk("rsthold_rdy",  {31'd0, sym_rdy_o},  32'd1);
        chk("rsthold_dat",  {24'd0, byte_dat_o}, 32'd0);
        byte_rdy_i = 1'b1;
        tick(2);
        chk("rsthold_no_hs", bytes_seen - b0, 0);
        send_frame(8'hCA);
        tick(2);
        chk("after_rst_cnt",  bytes_seen - b0, 1);
        chk("after_rst_data", {24'd0, last_byte}, 32'hCA);

`ifdef SYMBOL_DECODE_STAT_EN
        do_reset();
        chk("cnt_rst", {24'd0, err_cnt_o}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 40);
            send(1'b0, 20);
        end
        tick(3);
        chk("cnt_sat", {24'd0, err_cnt_o}, 32'd255);
        do_reset();
        chk("cnt_clr", {24'd0, err_cnt_o}, 32'd0);
`endif

        tick(2);
        chk("no_err_in_hold", err_in_hold, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/symbol_decode.md
SYMBOL_DECODE -- requirements
Module: symbol_decode

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of symbol length fields.
REQ-002 SHALL have parameter SHORT_MIN, default 8, minimum cycles for a short symbol.
REQ-003 SHALL have parameter SHORT_MAX, default 12, maximum cycles for a short symbol.
REQ-004 SHALL have parameter LONG_MIN, default 16, minimum cycles for a long symbol.
REQ-005 SHALL have parameter LONG_MAX, default 24, maximum cycles for a long symbol.
REQ-006 SHALL have parameter SYNC_MIN, default 40, minimum low-symbol length recognised as sync.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port sym_vld, input, 1, upstream measured symbol valid.
REQ-010 SHALL have port sym_rdy, output, 1, symbol accepted when sym_vld && sym_rdy.
REQ-011 SHALL have port sym_lvl, input, 1, line level of the measured symbol (1 = high pulse).
REQ-012 SHALL have port sym_len, input, LEN_W, measured symbol length in clk cycles.
REQ-013 SHALL have port byte_vld, output, 1, decoded byte valid.
REQ-014 SHALL have port byte_rdy, input, 1, downstream accepts byte when byte_vld && byte_rdy.
REQ-015 SHALL have port byte_dat, output, 8, decoded byte, first received bit in bit 7.
REQ-016 SHALL have port err_pls, output, 1, one-cycle pulse on framing/width error.

Function
REQ-017 SHALL classify each accepted symbol: SHORT if SHORT_MIN<=len<=SHORT_MAX; LONG if LONG_MIN<=len<=LONG_MAX; SYNC if sym_lvl=0 and len>=SYNC_MIN; otherwise BAD; unsigned LEN_W compares.
REQ-018 SHALL implement FSM states IDLE, DATA, HOLD.
REQ-019 IDLE: all symbols except SYNC are consumed and discarded without error; SYNC -> DATA with bit_cnt=0.
REQ-020 DATA, high symbol: SHORT shifts in 0, LONG shifts in 1, MSB first, bit_cnt+1.
REQ-021 DATA, low symbol: SHORT consumed with no data; SYNC restarts frame (bit_cnt=0, partial bits dropped, no error).
REQ-022 DATA: BAD symbol, high SYNC-length, or LONG low symbol -> err_pls=1 next cycle, state -> IDLE, partial byte discarded.
REQ-023 On the 8th data bit, SHALL load byte_dat and assert byte_vld the following cycle (1-cycle latency), state -> HOLD, bit_cnt=0.
REQ-024 HOLD: sym_rdy=0; byte_vld and byte_dat stable until byte_rdy=1; on handshake byte_vld drops next cycle, state -> DATA (framing kept).
REQ-025 sym_rdy SHALL be 1 in IDLE and DATA, 0 in HOLD; combinational from state only, never from sym_vld.
REQ-026 byte_vld asserted with byte_rdy already 1 SHALL complete in exactly one cycle; back-to-back bytes allowed.
REQ-027 err_pls SHALL be exactly one cycle per error, never asserted in HOLD.

Reset
REQ-028 rst=1 at any clock edge SHALL force state IDLE, bit_cnt=0, shift register=0, byte_dat=0, byte_vld=0, err_pls=0; sym_rdy=1 in cycle after reset.
REQ-029 Reset during HOLD SHALL drop pending byte without handshake; reset dominates every simultaneous event.

Configuration
REQ-030 Macro SYMBOL_DECODE_STAT_EN defined: SHALL add output err_cnt (8 bits), incrementing per err_pls, saturating at 255, cleared by rst.
REQ-031 Macro undefined: port err_cnt and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Low len 40, then 8 high symbols lens 10,20,10,20,10,20,10,20 each with low len 10, byte_rdy=1 -> byte_dat=0x55, byte_vld one cycle, no err_pls.
REQ-033 Sync, 8 high LONG lens 16 -> 0xFF; byte_rdy=0 for 5 cycles -> sym_rdy=0, byte_dat stable 5 cycles; then handshake.
REQ-034 Sync, 3 bits, high len 14 (gap) -> err_pls single pulse, state IDLE, subsequent non-sync symbols ignored, no byte.
REQ-035 Sync, 5 bits, low len 50 (resync), then 8 SHORT highs -> byte 0x00 only, no error.
REQ-036 rst asserted in HOLD with byte_vld=1 -> byte_vld=0 next cycle, sym_rdy=1, new frame decodes correctly.
REQ-037 With SYMBOL_DECODE_STAT_EN: 300 error events -> err_cnt=255; rst -> 0.
